bus_switch_mem_reg: RTL and testbench

- Registered, parametrised successor of the combinational memory-bus switch.
- Connects one Wishbone-style master to NSLAVE slaves.
- Address decode uses base/mask parameters.
- The slave select is latched for the whole transaction, and acks and read data are registered.
- Unmapped accesses and (optionally) hung slaves are terminated with a one-cycle error response.
- Sits between the CPU/BIU memory port and the memory-mapped peripherals.

---
 rtl/bus_switch_pkg.sv | 25 ++
 rtl/bus_addr_decoder.sv | 31 +++
 rtl/bus_switch_mem_reg.sv | 150 +++++++++++++++
 tb/tb_bus_switch_mem_reg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_switch_pkg.sv
// Shared definitions for the registered memory-bus switch: FSM encoding,
// default geometry and the default (all-zero) memory map.
package bus_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int DEF_NSLAVE = 8;
  localparam int DEF_AW     = 32;
  localparam int DEF_DW     = 32;

  // Default map: every slave at base 0 with mask 0, i.e. slave 0 claims all.
  localparam logic [DEF_NSLAVE*DEF_AW-1:0] DEF_SLAVE_BASE = '0;
  localparam logic [DEF_NSLAVE*DEF_AW-1:0] DEF_SLAVE_MASK = '0;

  // Index width that stays legal for a single-slave build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask address decoder with lowest-index priority.
module bus_addr_decoder
  import bus_switch_pkg::*;
#(
  parameter int                   NSLAVE = DEF_NSLAVE,
  parameter int                   AW     = DEF_AW,
  parameter logic [NSLAVE*AW-1:0] BASE   = '0,
  parameter logic [NSLAVE*AW-1:0] MASK   = '0,
  parameter int                   IW     = idx_w(NSLAVE)
) (
  input  logic [AW-1:0]     adr,
  output logic [NSLAVE-1:0] hit,
  output logic              hit_any,
  output logic [IW-1:0]     idx
);

  for (genvar i = 0; i < NSLAVE; i++) begin : g_cmp
    assign hit[i] = ((adr & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW]));
  end

  assign hit_any = |hit;

  // Priority encode: scan downwards so the lowest matching index wins.
  always_comb begin
    idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if (hit[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/bus_switch_mem_reg.sv
// Registered one-master / NSLAVE-slave Wishbone-style switch.
// Slave select and request fields are latched for the whole transaction;
// ack, err and read data are registered. Unmapped accesses end in a
// one-cycle error. Optional macro BUSSW_TIMEOUT_EN adds a wait-state
// watchdog that terminates hung slaves with an error.
module bus_switch_mem_reg
  import bus_switch_pkg::*;
#(
  parameter int                   NSLAVE         = DEF_NSLAVE,
  parameter int                   AW             = DEF_AW,
  parameter int                   DW             = DEF_DW,
  parameter logic [NSLAVE*AW-1:0] SLAVE_BASE     = (NSLAVE*AW)'(DEF_SLAVE_BASE),
  parameter logic [NSLAVE*AW-1:0] SLAVE_MASK     = (NSLAVE*AW)'(DEF_SLAVE_MASK),
  parameter int                   TIMEOUT_CYCLES = 255,
  localparam int                  SW             = DW / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 master_stb_i,
  input  logic                 master_we_i,
  input  logic [AW-1:0]        master_adr_i,
  input  logic [DW-1:0]        master_dat_i,
  input  logic [SW-1:0]        master_sel_i,
  output logic [DW-1:0]        master_dat_o,
  output logic                 master_ack_o,
  output logic                 master_err_o,
  output logic                 adr_err_o,
  output logic [AW-1:0]        err_adr_o,
  output logic [NSLAVE-1:0]    slave_stb_o,
  output logic [NSLAVE-1:0]    slave_cyc_o,
  output logic                 slave_we_o,
  output logic [AW-1:0]        slave_adr_o,
  output logic [DW-1:0]        slave_dat_o,
  output logic [SW-1:0]        slave_sel_o,
  input  logic [NSLAVE*DW-1:0] slave_dat_i,
  input  logic [NSLAVE-1:0]    slave_ack_i
);

  localparam int IW = idx_w(NSLAVE);

  state_e              state_q, state_d;
  logic [NSLAVE-1:0]   hit, stb_q;
  logic                hit_any, ack_sel, tmo;
  logic [IW-1:0]       dec_idx, idx_q;
  logic                we_q, adr_err_q;
  logic [AW-1:0]       adr_q, err_adr_q;
  logic [DW-1:0]       dat_q, rdat_q;
  logic [SW-1:0]       sel_q;

  bus_addr_decoder #(
    .NSLAVE (NSLAVE),
    .AW     (AW),
    .BASE   (SLAVE_BASE),
    .MASK   (SLAVE_MASK),
    .IW     (IW)
  ) u_dec (
    .adr     (master_adr_i),
    .hit     (hit),
    .hit_any (hit_any),
    .idx     (dec_idx)
  );

  // Only the latched slave's ack counts; strays from other ports are masked.
  assign ack_sel = (state_q == ST_WAIT) && |(slave_ack_i & stb_q);

`ifdef BUSSW_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wcnt_q;

  // Count WAIT cycles without ack; held at zero outside WAIT.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || state_q != ST_WAIT) wcnt_q <= '0;
    else if (!ack_sel)                  wcnt_q <= wcnt_q + CW'(1);
  end

  // Expire on the cycle whose increment would reach TIMEOUT_CYCLES,
  // so the strobe is held for exactly TIMEOUT_CYCLES WAIT cycles.
  assign tmo = (state_q == ST_WAIT) && (wcnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: TIMEOUT_CYCLES is never negative, so this is constant 0.
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; an ack on the expiry cycle takes priority over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (master_stb_i) state_d = hit_any ? ST_WAIT : ST_ERR;
      ST_WAIT: begin
        if (ack_sel)  state_d = ST_RESP;
        else if (tmo) state_d = ST_ERR;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, one-hot strobe, read-data capture and error bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stb_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rdat_q    <= '0;
      adr_err_q <= 1'b0;
      err_adr_q <= '0;
    end else begin
      if (state_q == ST_IDLE && master_stb_i) begin
        if (hit_any) begin
          // Isolate lowest set hit bit: same slave the priority encoder picks.
          stb_q <= hit & (~hit + NSLAVE'(1));
          idx_q <= dec_idx;
          we_q  <= master_we_i;
          adr_q <= master_adr_i;
          dat_q <= master_dat_i;
          sel_q <= master_sel_i;
        end else begin
          adr_err_q <= 1'b1;
          err_adr_q <= master_adr_i;
        end
      end
      if (ack_sel) rdat_q <= slave_dat_i[idx_q*DW +: DW];
      if (state_q == ST_WAIT && state_d != ST_WAIT) stb_q <= '0;
      if (state_q == ST_WAIT && !ack_sel && tmo) err_adr_q <= adr_q;
    end
  end

  assign slave_stb_o  = stb_q;
  assign slave_cyc_o  = stb_q;
  assign slave_we_o   = we_q;
  assign slave_adr_o  = adr_q;
  assign slave_dat_o  = dat_q;
  assign slave_sel_o  = sel_q;
  assign master_dat_o = rdat_q;
  assign master_ack_o = (state_q == ST_RESP);
  assign master_err_o = (state_q == ST_ERR);
  assign adr_err_o    = adr_err_q;
  assign err_adr_o    = err_adr_q;

endmodule

// File: tb/tb_bus_switch_mem_reg.sv
// Bench for bus_switch_mem_reg: a transaction-level timeline model predicts
// every output per cycle; directed tests add hand-computed literal checks.
module tb_bus_switch_mem_reg;

  localparam int NS = 4, AW = 32, DW = 32, SW = 4, NC = 1024;
  localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {4{32'hF000_0000}};
`ifdef BUSSW_TIMEOUT_EN
  localparam int TMO_T = 4;
`else
  localparam int TMO_T = 1 << 30;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdat;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] master_dat_o;
  logic master_ack_o, master_err_o, adr_err_o;
  logic [AW-1:0] err_adr_o, slave_adr_o;
  logic [NS-1:0] slave_stb_o, slave_cyc_o, slave_ack_i;
  logic slave_we_o;
  logic [DW-1:0] slave_dat_o;
  logic [SW-1:0] slave_sel_o;
  logic [NS*DW-1:0] slave_dat_i;

  always #5 clk = ~clk;

  bus_switch_mem_reg #(
    .NSLAVE(NS), .AW(AW), .DW(DW), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .master_stb_i(m_stb), .master_we_i(m_we), .master_adr_i(m_adr),
    .master_dat_i(m_wdat), .master_sel_i(m_sel),
    .master_dat_o(master_dat_o), .master_ack_o(master_ack_o), .master_err_o(master_err_o),
    .adr_err_o(adr_err_o), .err_adr_o(err_adr_o),
    .slave_stb_o(slave_stb_o), .slave_cyc_o(slave_cyc_o), .slave_we_o(slave_we_o),
    .slave_adr_o(slave_adr_o), .slave_dat_o(slave_dat_o), .slave_sel_o(slave_sel_o),
    .slave_dat_i(slave_dat_i), .slave_ack_i(slave_ack_i)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave responders: slave i acks combinationally on its (wait_st[i]+1)-th strobe cycle.
  int wait_st[NS];
  logic [DW-1:0] rd_data[NS];
  logic [NS-1:0] stray = '0;
  int scnt[NS];
  always @(posedge clk)
    for (int i = 0; i < NS; i++) scnt[i] <= slave_stb_o[i] ? scnt[i] + 1 : 0;
  always_comb begin
    slave_ack_i = '0;
    slave_dat_i = '0;
    for (int i = 0; i < NS; i++) begin
      slave_ack_i[i] = (slave_stb_o[i] && scnt[i] == wait_st[i]) || stray[i];
      slave_dat_i[i*DW +: DW] = rd_data[i];
    end
  end

  // Expected timeline, indexed by cycle number.
  logic [NS-1:0] e_stb[NC];
  logic e_ack[NC], e_err[NC], e_swe[NC];
  logic [AW-1:0] e_sadr[NC];
  logic [DW-1:0] e_sdat[NC];
  logic [SW-1:0] e_ssel[NC];
  logic u_dat_v[NC], u_ae_v[NC], u_ea_v[NC], u_rst[NC];
  logic [DW-1:0] u_dat[NC];
  logic [AW-1:0] u_ea[NC];

  int nchk = 0, nerr = 0, stb1_total = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW])) return i;
    return -1;
  endfunction

  // Per-cycle compare against the model timeline and held-value state.
  initial begin
    logic [DW-1:0] m_dat;
    logic m_ae;
    logic [AW-1:0] m_ea;
    m_dat = '0; m_ae = 1'b0; m_ea = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < NC) begin
        if (u_rst[cyc]) begin m_dat = '0; m_ae = 1'b0; m_ea = '0; end
        if (u_dat_v[cyc]) m_dat = u_dat[cyc];
        if (u_ae_v[cyc]) m_ae = 1'b1;
        if (u_ea_v[cyc]) m_ea = u_ea[cyc];
        if (slave_stb_o[1]) stb1_total++;
        chk("slave_stb", 64'(slave_stb_o), 64'(e_stb[cyc]));
        chk("slave_cyc", 64'(slave_cyc_o), 64'(e_stb[cyc]));
        chk("ack", 64'(master_ack_o), 64'(e_ack[cyc]));
        chk("err", 64'(master_err_o), 64'(e_err[cyc]));
        chk("rdat", 64'(master_dat_o), 64'(m_dat));
        chk("adr_err", 64'(adr_err_o), 64'(m_ae));
        chk("err_adr", 64'(err_adr_o), 64'(m_ea));
        if (e_stb[cyc] != '0) begin
          chk("s_we", 64'(slave_we_o), 64'(e_swe[cyc]));
          chk("s_adr", 64'(slave_adr_o), 64'(e_sadr[cyc]));
          chk("s_dat", 64'(slave_dat_o), 64'(e_sdat[cyc]));
          chk("s_sel", 64'(slave_sel_o), 64'(e_ssel[cyc]));
        end
      end
    end
  end

  // Present a request and schedule its predicted outcome.
  task automatic launch(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output int c0);
    int sl, k, n;
    @(posedge clk); #1;
    c0 = cyc;
    m_stb = 1'b1; m_we = we; m_adr = a; m_wdat = d; m_sel = s;
    sl = decode(a);
    if (sl < 0) begin
      e_err[c0+1] = 1'b1; u_ae_v[c0+1] = 1'b1; u_ea_v[c0+1] = 1'b1; u_ea[c0+1] = a;
    end else begin
      k = wait_st[sl];
      n = (k + 1 <= TMO_T) ? k + 1 : TMO_T;
      for (int j = 1; j <= n; j++) begin
        e_stb[c0+j] = NS'(1) << sl;
        e_swe[c0+j] = we; e_sadr[c0+j] = a; e_sdat[c0+j] = d; e_ssel[c0+j] = s;
      end
      if (k + 1 <= TMO_T) begin
        e_ack[c0+n+1] = 1'b1; u_dat_v[c0+n+1] = 1'b1; u_dat[c0+n+1] = rd_data[sl];
      end else begin
        e_err[c0+n+1] = 1'b1; u_ea_v[c0+n+1] = 1'b1; u_ea[c0+n+1] = a;
      end
    end
  endtask

  // Hold the request (scrambling write data/select) until ack or err, bounded.
  task automatic finish(output int cdone, output logic was_err);
    cdone = -1; was_err = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(posedge clk); #1;
      if (master_ack_o || master_err_o) begin
        cdone = cyc; was_err = master_err_o;
        break;
      end
      m_wdat = ~m_wdat; m_sel = ~m_sel;
    end
    m_stb = 1'b0;
    chk("completed", 64'(cdone >= 0), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, cd, r, s0;
    logic we_err;
    for (int i = 0; i < NC; i++) begin
      e_stb[i] = '0; e_ack[i] = 1'b0; e_err[i] = 1'b0; e_swe[i] = 1'b0;
      e_sadr[i] = '0; e_sdat[i] = '0; e_ssel[i] = '0;
      u_dat_v[i] = 1'b0; u_ae_v[i] = 1'b0; u_ea_v[i] = 1'b0; u_rst[i] = 1'b0;
      u_dat[i] = '0; u_ea[i] = '0;
    end
    rd_data[0] = 32'h1111_1111; rd_data[1] = 32'hDEAD_BEEF;
    rd_data[2] = 32'h2222_2222; rd_data[3] = 32'h3333_3333;
    for (int i = 0; i < NS; i++) wait_st[i] = 0;
    rst_n = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = '0; m_wdat = '0; m_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_rdat", 64'(master_dat_o), 64'd0);
    chk("rst_sadr", 64'(slave_adr_o), 64'd0);
    chk("rst_sdat", 64'(slave_dat_o), 64'd0);

    // Read hit, slave 1, two wait states.
    wait_st[1] = 2;
    s0 = stb1_total;
    launch(1'b0, 32'h1000_0040, 32'h0, 4'hF, c0);
    finish(cd, we_err);
    chk("rd_lat", 64'(cd - c0), 64'd4);
    chk("rd_err", 64'(we_err), 64'd0);
    chk("rd_dat_lit", 64'(master_dat_o), 64'hDEAD_BEEF);
    chk("rd_stb_cycles", 64'(stb1_total - s0), 64'd3);

    // Write, zero wait states: ack two cycles after stb.
    wait_st[1] = 0;
    launch(1'b1, 32'h1000_0004, 32'h1234_5678, 4'b0011, c0);
    finish(cd, we_err);
    chk("wr_lat", 64'(cd - c0), 64'd2);

    // Write with wait states: latched fields stable while master inputs change.
    wait_st[1] = 3;
    launch(1'b1, 32'h1000_0008, 32'hA5A5_0F0F, 4'b1100, c0);
    finish(cd, we_err);
    chk("wr3_lat", 64'(cd - c0), 64'd5);

`ifdef BUSSW_TIMEOUT_EN
    // Hung slave: strobe held 4 WAIT cycles, then error without adr_err.
    wait_st[3] = 100;
    launch(1'b0, 32'h2000_0020, 32'h0, 4'hF, c0);
    finish(cd, we_err);
    chk("tmo_err", 64'(we_err), 64'd1);
    chk("tmo_lat", 64'(cd - c0), 64'd5);
    chk("tmo_adr_err", 64'(adr_err_o), 64'd0);
    chk("tmo_err_adr", 64'(err_adr_o), 64'h2000_0020);
    // Ack on the expiry cycle wins.
    wait_st[3] = 3;
    launch(1'b0, 32'h2000_0024, 32'h0, 4'hF, c0);
    finish(cd, we_err);
    chk("tmo_race_err", 64'(we_err), 64'd0);
    chk("tmo_race_dat", 64'(master_dat_o), 64'h3333_3333);
    wait_st[3] = 0;
`endif

    // Unmapped access.
    launch(1'b0, 32'hF000_0000, 32'h0, 4'hF, c0);
    finish(cd, we_err);
    chk("miss_lat", 64'(cd - c0), 64'd1);
    chk("miss_err", 64'(we_err), 64'd1);
    chk("miss_adr_err", 64'(adr_err_o), 64'd1);
    chk("miss_err_adr", 64'(err_adr_o), 64'hF000_0000);
    launch(1'b0, 32'h2000_0000, 32'h0, 4'hF, c0);
    finish(cd, we_err);
    chk("sticky_adr_err", 64'(adr_err_o), 64'd1);
    chk("s3_dat", 64'(master_dat_o), 64'h3333_3333);

    // Overlap (slaves 0 and 2) and stray ack from slave 2.
    wait_st[0] = 2;
    launch(1'b0, 32'h0000_0100, 32'h0, 4'hF, c0);
    stray = 4'b0100;
    finish(cd, we_err);
    stray = '0;
    chk("ovl_lat", 64'(cd - c0), 64'd4);
    chk("ovl_dat", 64'(master_dat_o), 64'h1111_1111);

    // Reset mid-WAIT.
    wait_st[3] = 10;
    launch(1'b0, 32'h2000_0010, 32'h0, 4'hF, c0);
    repeat (3) @(posedge clk);
    #1;
    r = cyc;
    rst_n = 1'b0; m_stb = 1'b0;
    for (int j = r + 1; j < NC; j++) begin
      e_stb[j] = '0; e_ack[j] = 1'b0; e_err[j] = 1'b0;
      u_dat_v[j] = 1'b0; u_ae_v[j] = 1'b0; u_ea_v[j] = 1'b0;
    end
    u_rst[r+1] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_stb", 64'(slave_stb_o), 64'd0);
    chk("mid_rst_adr_err", 64'(adr_err_o), 64'd0);
    chk("mid_rst_sadr", 64'(slave_adr_o), 64'd0);
    repeat (12) @(posedge clk);
    wait_st[3] = 1;
    launch(1'b0, 32'h2000_0014, 32'h0, 4'hF, c0);
    finish(cd, we_err);
    chk("post_rst_lat", 64'(cd - c0), 64'd3);
    chk("post_rst_dat", 64'(master_dat_o), 64'h3333_3333);

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
